// File: rtl/icache_ctrl_if.sv
// Fetch-side and refill-side signals of the instruction cache controller.
// The slave modport is the cache. The master modport is the core plus the backing memory.
interface icache_ctrl_if;
  logic        cpu_rd_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_rd_en, cpu_addr, invalidate, mem_ack, mem_rdata,
    output cpu_rdata, cpu_ready, mem_req, mem_addr
  );

  modport master (
    output cpu_rd_en, cpu_addr, invalidate, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped blocking instruction cache. A hit returns data combinationally in the same cycle.
// A miss stalls the core while the line refills one word per acknowledged beat; a low mem_ack holds the beat.
module icache_ctrl #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  icache_ctrl_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W - 2;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [0:0]           state;
  logic [OFF_W-1:0]     beat;
  logic [TAG_W-1:0]     fill_tag;
  logic [IDX_W-1:0]     fill_idx;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0] cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             lookup;
  logic             hit;
  logic             miss;
  logic             last_beat;
  logic             beat_done;

  assign cpu_off = bus.cpu_addr[2 +: OFF_W];
  assign cpu_idx = bus.cpu_addr[OFF_W+2 +: IDX_W];
  assign cpu_tag = bus.cpu_addr[31 -: TAG_W];

  // An invalidate in IDLE blocks the lookup that cycle, so the cycle is neither a hit nor a miss.
  assign lookup = (state == IDLE) && bus.cpu_rd_en && !bus.invalidate;
  assign hit    = lookup && valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
  assign miss   = lookup && !hit;

  assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));
  assign beat_done = (state == REFILL) && bus.mem_ack && !bus.invalidate;

  assign bus.cpu_ready = hit;
  assign bus.cpu_rdata = hit ? data[cpu_idx][cpu_off] : 32'h0;
  assign bus.mem_req   = (state == REFILL);
  assign bus.mem_addr  = (state == REFILL) ? {fill_tag, fill_idx, beat, 2'b00} : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      valid    <= '0;
    end else begin
      if (bus.invalidate) begin
        valid <= '0;
      end
      case (state)
        IDLE: begin
          if (miss) begin
            fill_tag <= cpu_tag;
            fill_idx <= cpu_idx;
            beat     <= '0;
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (bus.invalidate) begin
            beat  <= '0;
            state <= IDLE;
          end else if (bus.mem_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[fill_idx] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (beat_done) begin
      data[fill_idx][beat] <= bus.mem_rdata;
      if (last_beat) begin
        tags[fill_idx] <= fill_tag;
      end
    end
  end
endmodule
